soc_bram_ctl: RTL and testbench

Bus-side controller placed directly upstream of the byte-lane block RAMs in the SoC. It accepts single 32-bit read and write requests from the core's memory bus, with byte-lane write masking. It drives four 8-bit-wide `soc_bram` instances (one per byte lane, sharing one word address) and absorbs their one-cycle registered read latency. Each completed request is returned with a one-cycle `ack` pulse, plus an error flag for out-of-range addresses.

---
 rtl/soc_bram_ctl.sv | 119 +++++++++++
 tb/tb_soc_bram_ctl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bram_ctl.sv
// Bus-side controller for four byte-lane block RAMs: single 32-bit reads and
// masked writes, range checking, and absorption of the one-cycle read latency.
module soc_bram_ctl #(
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stb,
    input  logic                  rw,
    input  logic [31:0]           addr,
    input  logic [31:0]           dtw,
    input  logic [3:0]            wmask,
    output logic [31:0]           dtr,
    output logic                  ack,
    output logic                  err,
    output logic                  busy,
    output logic [addr_width-1:0] bram_addr,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  rw_q;
    logic [addr_width-1:0] idx_q;
    logic [31:0]           data_q;
    logic [3:0]            we_q;
    logic [31:0]           dtr_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  busy_q;

    logic [addr_width-1:0] idx_d;
    logic                  in_range_d;
    logic                  unused_addr_bits;

    assign idx_d            = addr[addr_width+1:2];
    assign in_range_d       = ~|addr[31:addr_width+2];
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    // The captured wmask lives directly in we_q: it is loaded only for an
    // in-range write and cleared on the edge that leaves ACCESS.
    // NOTE: every state register uses non-blocking assignment so all of them
    // see the same pre-edge values; the RAM arrays themselves are never reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            we_q    <= 4'b0000;
            dtr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            we_q  <= 4'b0000;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (stb) begin
                        rw_q   <= rw;
                        idx_q  <= idx_d;
                        data_q <= dtw;
                        if (in_range_d) begin
                            state_q <= S_ACCESS;
                            busy_q  <= 1'b1;
                            we_q    <= rw ? wmask : 4'b0000;
                        end else begin
                            state_q <= S_DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            dtr_q   <= '0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (rw_q) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Lane outputs now hold the word addressed during ACCESS.
                    dtr_q   <= bram_dout;
                    state_q <= S_DONE;
                    ack_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dtr       = dtr_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign bram_addr = idx_q;
    assign bram_we   = we_q;
    assign bram_din  = data_q;

endmodule

// File: tb/tb_soc_bram_ctl.sv
// Randomized self-checking bench for soc_bram_ctl with behavioural byte-lane
// RAMs and a word-level reference memory.
module tb_soc_bram_ctl;

    localparam int AW    = 8;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stb = 1'b0;
    logic          rw = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   dtw = '0;
    logic [3:0]    wmask = '0;
    logic [31:0]   dtr;
    logic          ack;
    logic          err;
    logic          busy;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [WORDS];
    logic [31:0] ref_dtr = '0;

    soc_bram_ctl #(.addr_width(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .stb       (stb),
        .rw        (rw),
        .addr      (addr),
        .dtw       (dtw),
        .wmask     (wmask),
        .dtr       (dtr),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    always #5 clk = ~clk;

    // Four 8-bit lanes: registered output, holds while that lane is written.
    logic [7:0] lane_mem [4][WORDS];
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (bram_we[n]) lane_mem[n][bram_addr] <= bram_din[8*n +: 8];
            else            bram_dout[8*n +: 8]    <= lane_mem[n][bram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++)
            if (m[n]) r[8*n +: 8] = new_w[8*n +: 8];
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},  32'(ack), 32'd0);
        check({tag, "_err"},  32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_dtr"},  dtr, 32'd0);
        check({tag, "_we"},   32'(bram_we), 32'd0);
        check({tag, "_addr"}, 32'(bram_addr), 32'd0);
        check({tag, "_din"},  bram_din, 32'd0);
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ack_idle", 32'(ack), 32'd0);
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge where
    // ack is seen so a following call lands in the DONE cycle.
    task automatic do_req(input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input bit glitch);
        logic        oor = |a[31:AW+2];
        int          word = int'(a[AW+1:2]);
        int          exp_lat;
        int          lat = 0;
        bit          got_ack = 1'b0;
        bit          we_seen = 1'b0;
        exp_lat = oor ? 1 : (r ? 2 : 3);
        stb = 1'b1; rw = r; addr = a; dtw = d; wmask = m;
        while (!got_ack && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                if (glitch) begin
                    rw = 1'b1; dtw = ~ref_mem[word]; wmask = 4'hF;
                end else begin
                    stb = 1'b0;
                end
                if (!oor) begin
                    check("we_access", 32'(bram_we), r ? 32'(m) : 32'd0);
                    check("busy_access", 32'(busy), 32'd1);
                end
            end else if (lat == 2) begin
                stb = 1'b0;
            end
            if ((oor || !r) && bram_we != 4'b0000) we_seen = 1'b1;
            got_ack = ack;
        end
        stb = 1'b0;
        check("ack_latency", 32'(lat), 32'(exp_lat));
        if (oor)       ref_dtr = '0;
        else if (r)    ref_mem[word] = merge(ref_mem[word], d, m);
        else           ref_dtr = ref_mem[word];
        check("err", 32'(err), 32'(oor));
        check("dtr", dtr, ref_dtr);
        check("busy_done", 32'(busy), 32'd0);
        if (oor || !r) check("we_never", 32'(we_seen), 32'd0);
    endtask

    // Start a full-mask write (r=1) or a read (r=0) and reset it mid-flight.
    task automatic reset_mid(input logic r, input logic [31:0] a, input logic [31:0] d);
        stb = 1'b1; rw = r; addr = a; dtw = d; wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        if (r) check("pre_reset_we", 32'(bram_we), 32'hF);
        if (!r) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check_all_zero(r ? "rst_wr" : "rst_rd");
        @(negedge clk);
        check("rst_hold_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        ref_dtr = '0;
        idle(3);
        do_req(1'b0, a, 32'd0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic        r;
        bit          g;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < WORDS; i++)
            do_req(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0);
        idle(1);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        idle(1);
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
        check("read_0x10", dtr, 32'hDEADBEEF);

        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_req(1'b0, 32'h20, 32'd0, 4'h0, 1'b0);
        check("partial_0x20", dtr, 32'h11BB33DD);

        do_req(1'b1, 32'h24, 32'h55667788, 4'h0, 1'b0);
        do_req(1'b0, 32'h24, 32'd0, 4'h0, 1'b0);

        idle(2);
        do_req(1'b0, 32'h400, 32'd0, 4'h0, 1'b0);
        check("oor_dtr", dtr, 32'd0);
        idle(1);

        for (int i = 0; i < 6; i++) begin
            do_req(1'b1, 32'h3C, $urandom, 4'hF, 1'b0);
            do_req(1'b0, 32'h3C, 32'd0, 4'h0, 1'b0);
        end
        idle(1);

        do_req(1'b0, 32'h3C, 32'd0, 4'h0, 1'b1);
        idle(1);
        do_req(1'b0, 32'h3C, 32'd0, 4'h0, 1'b0);
        idle(1);

        reset_mid(1'b1, 32'h44, 32'hCAFEF00D);
        idle(1);
        reset_mid(1'b0, 32'h48, 32'd0);
        idle(1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(7) == 0)
                a = $urandom | (32'd1 << (AW + 2 + $urandom_range(31 - (AW + 2))));
            else
                a = 32'($urandom_range(4 * WORDS - 1));
            r = 1'($urandom_range(1));
            g = !r && !(|a[31:AW+2]) && ($urandom_range(3) == 0);
            do_req(r, a, $urandom, 4'($urandom_range(15)), g);
            if ($urandom_range(1) == 1) idle($urandom_range(2));
        end

        for (int i = 0; i < 16; i++)
            do_req(1'b0, 32'($urandom_range(4 * WORDS - 1)), 32'd0, 4'h0, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
